comp_pair_monitor: RTL
======================

COMP_PAIR_MONITOR -- requirements
Module: comp_pair_monitor

Interface
REQ-001 Parameter FILT_LEN, default 2, SHALL set the number of consecutive equal-pair samples that declares a fault; legal range 2..15.
REQ-002 Parameter CNT_W, default 8, SHALL set the width of fault_cnt and tog_cnt.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port rstn, input, 1, SHALL be the reset: synchronous, active-low.
REQ-005 Port c_in, input, 1, SHALL carry the true (buffered) output of the upstream buf/not gate stage.
REQ-006 Port d_in, input, 1, SHALL carry the complement (inverted) output of the same stage.
REQ-007 Port clr_err, input, 1, SHALL be a synchronous clear request for fault and fault_cnt.
REQ-008 Port fault, output, 1, SHALL be a sticky, registered flag: the pair lost complementarity.
REQ-009 Port fault_cnt, output, CNT_W, SHALL be the saturating count of fault events.
REQ-010 Port tog_cnt, output, CNT_W, SHALL be the saturating count of sampled c rising edges.
REQ-011 Port state, output, 2, SHALL be the current FSM state encoding: IDLE=0, OK=1, SUSPECT=2, FAULT=3.

Function
REQ-012 Sampled pair (c,d) SHALL mean c_in/d_in as seen after the optional synchronizer (REQ-026/027); "equal" SHALL mean c==d.
REQ-013 IDLE: equal -> stay in IDLE with no fault counting; c!=d -> OK.
REQ-014 OK: c!=d -> stay; equal -> SUSPECT with the suspect counter set to 1.
REQ-015 SUSPECT: c!=d -> OK with the suspect counter cleared; equal and suspect counter == FILT_LEN-1 -> FAULT (fault event); otherwise equal -> stay and increment the suspect counter.
REQ-016 FAULT: equal -> stay, with no further events; c!=d -> OK.
REQ-017 A fault event SHALL set fault=1 and increment fault_cnt on the same edge that samples the FILT_LEN-th consecutive equal pair.
REQ-018 fault_cnt SHALL saturate at 2^CNT_W-1.
REQ-019 fault SHALL remain 1 after the state leaves FAULT, until clr_err or reset.
REQ-020 clr_err=1 SHALL clear fault and fault_cnt on that edge; it SHALL NOT change state or tog_cnt.
REQ-021 clr_err coincident with a fault event: the event SHALL win, giving fault=1 and fault_cnt=1.
REQ-022 tog_cnt SHALL increment, saturating, when the sampled c is 1 and the previous sampled c was 0; the first sample after reset SHALL NOT count as an edge.
REQ-023 The suspect counter SHALL be 4 bits wide and internal.

Reset
REQ-024 rstn=0 at a rising clk SHALL set state=IDLE, fault=0, fault_cnt=0, tog_cnt=0, suspect counter=0, previous-c register=0, and all synchronizer flops=0.
REQ-025 Reset SHALL override clr_err and any in-progress SUSPECT run; a run interrupted by reset SHALL NOT produce a fault.

Configuration
REQ-026 Macro CPM_SYNC_EN defined: c_in and d_in SHALL each pass through a 2-flop synchronizer, so all responses lag the pins by 2 extra cycles.
REQ-027 CPM_SYNC_EN undefined: c_in and d_in SHALL be sampled directly with no added latency; the port list is identical in both builds.

Verification (CPM_SYNC_EN undefined unless stated; FILT_LEN=2, CNT_W=8)
REQ-028 Reset, then hold c=0,d=0 for 5 cycles -> state=IDLE throughout, fault=0, fault_cnt=0.
REQ-029 c=1,d=0 for 1 cycle, then c=1,d=1 for 2 cycles -> state 1->2->3; fault=1 and fault_cnt=1 at the 2nd equal edge.
REQ-030 From OK: equal for 1 cycle, then complementary -> state 2->1, fault stays 0; then assert clr_err while equal for 2 cycles -> fault=1, fault_cnt=1 (event wins).
REQ-031 Drive c=0,1,0,1,0,1 with d=~c -> tog_cnt=3 and fault=0; 300 fault events -> fault_cnt holds at 255.
REQ-032 Enter SUSPECT, then assert rstn=0 for 1 cycle -> all outputs at reset values; state=IDLE; no fault.
REQ-033 CPM_SYNC_EN defined: repeat REQ-029 -> identical response sequence delayed by exactly 2 cycles.

Source files
------------

// File: rtl/comp_pair_monitor.sv
// comp_pair_monitor: watches a buf/not gate output pair (c, d) for loss of
// complementarity.
//   FILT_LEN consecutive equal samples raise a sticky fault. The block also
//   counts fault events and rising edges of c.
// Ports:
//   clk      - clock, rising edge
//   rstn     - synchronous active-low reset
//   c_in     - true output of the gate stage
//   d_in     - complement output of the gate stage
//   clr_err  - clears fault and fault_cnt
//   fault    - sticky flag, set when the pair loses complementarity
//   fault_cnt- saturating count of fault events
//   tog_cnt  - saturating count of rising edges of the sampled c
//   state    - FSM state: IDLE=0, OK=1, SUSPECT=2, FAULT=3
// Build option:
//   CPM_SYNC_EN adds a 2-flop synchronizer on c_in and d_in, which delays
//   every response by 2 cycles.
module comp_pair_monitor #(
   parameter int FILT_LEN = 2,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             c_in,
   input  logic             d_in,
   input  logic             clr_err,
   output logic             fault,
   output logic [CNT_W-1:0] fault_cnt,
   output logic [CNT_W-1:0] tog_cnt,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OK   = 2'd1,
      SUSP = 2'd2,
      FLT  = 2'd3
   } st_t;

   localparam logic [3:0]       SLAST = 4'(FILT_LEN - 1);
   localparam logic [CNT_W-1:0] CMAX  = '1;

   logic c_s;
   logic d_s;

`ifdef CPM_SYNC_EN
   logic [1:0] csync_q;
   logic [1:0] dsync_q;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         csync_q <= 2'b00;
         dsync_q <= 2'b00;
      end else begin
         csync_q <= {csync_q[0], c_in};
         dsync_q <= {dsync_q[0], d_in};
      end
   end

   assign c_s = csync_q[1];
   assign d_s = dsync_q[1];
`else
   assign c_s = c_in;
   assign d_s = d_in;
`endif

   logic eq;
   assign eq = (c_s == d_s);

   st_t              state_q, state_d;
   logic [3:0]       scnt_q, scnt_d;
   logic             fault_q, fault_d;
   logic [CNT_W-1:0] fcnt_q, fcnt_d;
   logic [CNT_W-1:0] tcnt_q, tcnt_d;
   logic             prevc_q;
   logic             seen_q;
   logic             event_s;

   // State register
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= IDLE;
         scnt_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         scnt_q  <= scnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      scnt_d  = scnt_q;
      unique case (state_q)
         IDLE: begin
            if (!eq) state_d = OK;
         end
         OK: begin
            if (eq) begin
               state_d = SUSP;
               scnt_d  = 4'd1;
            end
         end
         SUSP: begin
            if (!eq) begin
               state_d = OK;
               scnt_d  = 4'd0;
            end else if (scnt_q == SLAST) begin
               state_d = FLT;
               scnt_d  = 4'd0;
            end else begin
               scnt_d = scnt_q + 4'd1;
            end
         end
         FLT: begin
            if (!eq) state_d = OK;
         end
      endcase
   end

   // Output / counter logic; a fault event beats a coincident clear
   always_comb begin
      event_s = (state_q == SUSP) && eq && (scnt_q == SLAST);
      fault_d = fault_q;
      fcnt_d  = fcnt_q;
      tcnt_d  = tcnt_q;
      if (event_s) begin
         fault_d = 1'b1;
         if (clr_err)
            fcnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
         else if (fcnt_q != CMAX)
            fcnt_d = fcnt_q + 1'b1;
      end else if (clr_err) begin
         fault_d = 1'b0;
         fcnt_d  = '0;
      end
      // seen_q masks the first sample after reset
      if (seen_q && c_s && !prevc_q && (tcnt_q != CMAX))
         tcnt_d = tcnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         fault_q <= 1'b0;
         fcnt_q  <= '0;
         tcnt_q  <= '0;
         prevc_q <= 1'b0;
         seen_q  <= 1'b0;
      end else begin
         fault_q <= fault_d;
         fcnt_q  <= fcnt_d;
         tcnt_q  <= tcnt_d;
         prevc_q <= c_s;
         seen_q  <= 1'b1;
      end
   end

   assign fault     = fault_q;
   assign fault_cnt = fcnt_q;
   assign tog_cnt   = tcnt_q;
   assign state     = state_q;

endmodule
